// File: rtl/vdc_cpu_port_ctrl.sv
// CPU-side data bus buffer for the VDC: decodes 8-bit port accesses, latches the data
// low byte, and runs VRAM write/prefetch cycles with MAWR/MARR auto-increment.
module vdc_cpu_port_ctrl #(
  parameter int AW = 16
) (
  input  logic          i_clock,
  input  logic          i_reset_n,
  input  logic          i_cpu_wr,
  input  logic          i_cpu_rd,
  input  logic [1:0]    i_cpu_addr,
  input  logic [7:0]    i_cpu_din,
  output logic [7:0]    o_cpu_dout,
  input  logic [1:0]    i_inc_sel,
  output logic          o_reg_wr,
  output logic [4:0]    o_reg_sel,
  output logic [15:0]   o_reg_wdata,
  output logic          o_vram_req,
  output logic          o_vram_we,
  output logic [AW-1:0] o_vram_addr,
  output logic [15:0]   o_vram_wdata,
  input  logic          i_vram_ack,
  input  logic [15:0]   i_vram_rdata,
  output logic          o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD} state_t;

  state_t        r_state;
  logic [4:0]    r_ar;
  logic [AW-1:0] r_mawr, r_marr;
  logic [7:0]    r_latch;
  logic [15:0]   r_rbuf;
  logic          r_overrun;
  logic          r_vram_req, r_vram_we;

  logic          w_ack, w_hi_wr, w_wcmd, w_rcmd, w_free;
  logic [15:0]   w_word;
  logic [AW-1:0] w_inc, w_mawr_inc, w_marr_inc, w_mawr_nxt, w_marr_nxt;

  always_comb begin
    w_inc = '0;
    case (i_inc_sel)
      2'd0:    w_inc[0] = 1'b1;
      2'd1:    w_inc[5] = 1'b1;
      2'd2:    w_inc[6] = 1'b1;
      default: w_inc[7] = 1'b1;
    endcase
  end

  assign w_ack   = i_vram_ack && (r_state != S_IDLE);
  assign w_hi_wr = i_cpu_wr && (i_cpu_addr == 2'd3);
  assign w_word  = {i_cpu_din, r_latch};
  assign w_wcmd  = w_hi_wr && (r_ar == 5'd2);
  assign w_rcmd  = (w_hi_wr && (r_ar == 5'd1)) ||
                   (i_cpu_rd && (i_cpu_addr == 2'd3) && (r_ar == 5'd2));
  // The completing cycle frees the port in the same edge, so an ack-coincident command is taken.
  assign w_free  = (r_state == S_IDLE) || w_ack;

  assign w_mawr_inc = (w_ack && r_state == S_WR) ? r_mawr + w_inc : r_mawr;
  assign w_marr_inc = (w_ack && r_state == S_RD) ? r_marr + w_inc : r_marr;
  assign w_mawr_nxt = (w_hi_wr && r_ar == 5'd0) ? AW'(w_word) : w_mawr_inc;
  assign w_marr_nxt = (w_hi_wr && r_ar == 5'd1) ? AW'(w_word) : w_marr_inc;

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state      <= S_IDLE;
      r_vram_req   <= 1'b0;
      r_vram_we    <= 1'b0;
      o_vram_addr  <= '0;
      o_vram_wdata <= '0;
    end else if (w_wcmd && w_free) begin
      r_state      <= S_WR;
      r_vram_req   <= 1'b1;
      r_vram_we    <= 1'b1;
      o_vram_addr  <= w_mawr_inc;
      o_vram_wdata <= w_word;
    end else if (w_rcmd && w_free) begin
      r_state      <= S_RD;
      r_vram_req   <= 1'b1;
      r_vram_we    <= 1'b0;
      o_vram_addr  <= w_marr_nxt;
    end else if (w_ack) begin
      r_state      <= S_IDLE;
      r_vram_req   <= 1'b0;
      r_vram_we    <= 1'b0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_ar        <= '0;
      r_mawr      <= '0;
      r_marr      <= '0;
      r_latch     <= '0;
      r_rbuf      <= '0;
      r_overrun   <= 1'b0;
      o_cpu_dout  <= '0;
      o_reg_wr    <= 1'b0;
      o_reg_sel   <= '0;
      o_reg_wdata <= '0;
    end else begin
      r_mawr   <= w_mawr_nxt;
      r_marr   <= w_marr_nxt;
      o_reg_wr <= 1'b0;
      if (i_cpu_wr) begin
        case (i_cpu_addr)
          2'd0: r_ar <= i_cpu_din[4:0];
          2'd2: r_latch <= i_cpu_din;
          2'd3: if (r_ar > 5'd2) begin
            o_reg_wr    <= 1'b1;
            o_reg_sel   <= r_ar;
            o_reg_wdata <= w_word;
          end
          default: ;
        endcase
      end
      if (w_ack && r_state == S_RD) r_rbuf <= i_vram_rdata;
      // Reads see the buffer as it stood before any prefetch completing or starting now.
      if (i_cpu_rd) begin
        case (i_cpu_addr)
          2'd0:    o_cpu_dout <= {r_vram_req, r_overrun, 1'b0, r_ar};
          2'd2:    o_cpu_dout <= (r_ar == 5'd2) ? r_rbuf[7:0] : 8'h00;
          2'd3:    o_cpu_dout <= (r_ar == 5'd2) ? r_rbuf[15:8] : 8'h00;
          default: o_cpu_dout <= 8'h00;
        endcase
      end
      if ((w_wcmd || w_rcmd) && !w_free) r_overrun <= 1'b1;
      else if (i_cpu_rd && i_cpu_addr == 2'd0) r_overrun <= 1'b0;
    end
  end

  assign o_vram_req = r_vram_req;
  assign o_vram_we  = r_vram_we;
  assign o_busy     = r_vram_req;

endmodule

// File: tb/tb_vdc_cpu_port_ctrl.sv
// Directed bench for vdc_cpu_port_ctrl: a transaction-level model is compared every
// cycle, and literal expectations pin the scenario results.
module tb_vdc_cpu_port_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cpu_wr = 1'b0, cpu_rd = 1'b0, ack = 1'b0;
  logic [1:0]  cpu_addr = '0, inc_sel = '0;
  logic [7:0]  cpu_din = '0;
  logic [15:0] rdata = '0;
  logic [7:0]  dout;
  logic        reg_wr, vreq, vwe, busy;
  logic [4:0]  reg_sel;
  logic [15:0] reg_wdata, vaddr, vwdata;

  int n_chk = 0, n_err = 0;

  vdc_cpu_port_ctrl #(.AW(16)) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_cpu_wr(cpu_wr), .i_cpu_rd(cpu_rd),
    .i_cpu_addr(cpu_addr), .i_cpu_din(cpu_din), .o_cpu_dout(dout),
    .i_inc_sel(inc_sel), .o_reg_wr(reg_wr), .o_reg_sel(reg_sel),
    .o_reg_wdata(reg_wdata), .o_vram_req(vreq), .o_vram_we(vwe),
    .o_vram_addr(vaddr), .o_vram_wdata(vwdata), .i_vram_ack(ack),
    .i_vram_rdata(rdata), .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state: one outstanding VRAM transaction (m_act) plus the programmer-visible registers.
  logic [4:0]  m_ar, m_regsel;
  logic [15:0] m_mawr, m_marr, m_rbuf, m_addr, m_wdata, m_regwdata;
  logic [7:0]  m_latch, m_dout;
  bit          m_ovr, m_act, m_we, m_regwr;

  task automatic model_step();
    logic [15:0] inc, word;
    bit cw, cr;
    if (!rst_n) begin
      m_ar = 0; m_regsel = 0; m_mawr = 0; m_marr = 0; m_rbuf = 0; m_addr = 0;
      m_wdata = 0; m_regwdata = 0; m_latch = 0; m_dout = 0;
      m_ovr = 0; m_act = 0; m_we = 0; m_regwr = 0;
      return;
    end
    inc = (inc_sel == 2'd0) ? 16'd1 : (16'd1 << (4 + int'(inc_sel)));
    if (cpu_rd) begin
      case (cpu_addr)
        2'd0: m_dout = {m_act, m_ovr, 1'b0, m_ar};
        2'd1: m_dout = 8'h00;
        2'd2: m_dout = (m_ar == 5'd2) ? m_rbuf[7:0] : 8'h00;
        2'd3: m_dout = (m_ar == 5'd2) ? m_rbuf[15:8] : 8'h00;
      endcase
      if (cpu_addr == 2'd0) m_ovr = 0;
    end
    if (ack && m_act) begin
      if (m_we) m_mawr = m_mawr + inc;
      else begin m_rbuf = rdata; m_marr = m_marr + inc; end
      m_act = 0;
    end
    m_regwr = 0; cw = 0; cr = 0;
    word = {cpu_din, m_latch};
    if (cpu_wr) begin
      if (cpu_addr == 2'd0) m_ar = cpu_din[4:0];
      else if (cpu_addr == 2'd2) m_latch = cpu_din;
      else if (cpu_addr == 2'd3) begin
        if (m_ar == 5'd0) m_mawr = word;
        else if (m_ar == 5'd1) begin m_marr = word; cr = 1; end
        else if (m_ar == 5'd2) cw = 1;
        else begin m_regwr = 1; m_regsel = m_ar; m_regwdata = word; end
      end
    end
    if (cpu_rd && cpu_addr == 2'd3 && m_ar == 5'd2) cr = 1;
    if (cw || cr) begin
      if (m_act) m_ovr = 1;
      else begin
        m_act = 1; m_we = cw;
        m_addr = cw ? m_mawr : m_marr;
        if (cw) m_wdata = word;
      end
    end
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    chk("vram_req", vreq, m_act);
    chk("busy", busy, m_act);
    if (m_act) begin
      chk("vram_we", vwe, m_we);
      chk("vram_addr", vaddr, m_addr);
      if (m_we) chk("vram_wdata", vwdata, m_wdata);
    end
    chk("reg_wr", reg_wr, m_regwr);
    if (m_regwr) begin
      chk("reg_sel", reg_sel, m_regsel);
      chk("reg_wdata", reg_wdata, m_regwdata);
    end
    chk("cpu_dout", dout, m_dout);
  end

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cpu_wr = 1; cpu_addr = a; cpu_din = d;
    @(negedge clk);
    cpu_wr = 0;
  endtask

  task automatic rd(input logic [1:0] a);
    cpu_rd = 1; cpu_addr = a;
    @(negedge clk);
    cpu_rd = 0;
  endtask

  task automatic pulse_ack(input logic [15:0] d);
    ack = 1; rdata = d;
    @(negedge clk);
    ack = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    idle(3);
    chk("rst_dout", dout, 8'h00);
    chk("rst_req", vreq, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_reg_wr", reg_wr, 1'b0);
    chk("rst_vaddr", vaddr, 16'h0000);
    chk("rst_reg_wdata", reg_wdata, 16'h0000);
    rst_n = 1;
    idle(1);

    // write with increment
    wr(0, 8'h00); wr(2, 8'h34); wr(3, 8'h12);
    wr(0, 8'h02); wr(2, 8'hCD); wr(3, 8'hAB);
    chk("t1_req", vreq, 1'b1); chk("t1_we", vwe, 1'b1);
    chk("t1_addr", vaddr, 16'h1234); chk("t1_wdata", vwdata, 16'hABCD);
    idle(2);
    pulse_ack(16'h0000);
    chk("t1_busy_fall", busy, 1'b0);
    chk("t1_model_mawr", m_mawr, 16'h1235);
    wr(3, 8'h00);
    chk("t1_addr2", vaddr, 16'h1235); chk("t1_wdata2", vwdata, 16'h00CD);
    pulse_ack(16'h0000);

    // prefetch
    wr(0, 8'h01); wr(2, 8'h00); wr(3, 8'h01);
    chk("t2_we", vwe, 1'b0); chk("t2_addr", vaddr, 16'h0100);
    pulse_ack(16'hBEEF);
    wr(0, 8'h02);
    rd(2); chk("t2_lo", dout, 8'hEF);
    rd(3); chk("t2_hi", dout, 8'hBE);
    chk("t2_pf_req", vreq, 1'b1); chk("t2_pf_addr", vaddr, 16'h0101);
    pulse_ack(16'h5678);
    chk("t2_model_marr", m_marr, 16'h0102);

    // increment sizes and wrap
    inc_sel = 2'd3;
    wr(0, 8'h00); wr(2, 8'hF0); wr(3, 8'hFF);
    wr(0, 8'h02); wr(3, 8'h55);
    chk("t3_addr", vaddr, 16'hFFF0); chk("t3_wdata", vwdata, 16'h55F0);
    pulse_ack(16'h0000);
    chk("t3_model_wrap", m_mawr, 16'h0070);
    wr(3, 8'h66); chk("t3_addr_wrap", vaddr, 16'h0070);
    inc_sel = 2'd1;
    pulse_ack(16'h0000);
    wr(3, 8'h77); chk("t3_addr_inc32", vaddr, 16'h0090);
    pulse_ack(16'h0000);

    // overrun
    wr(3, 8'h11);
    chk("t4_addr", vaddr, 16'h00B0); chk("t4_wdata", vwdata, 16'h11F0);
    idle(1);
    wr(3, 8'h22);
    chk("t4_drop_addr", vaddr, 16'h00B0); chk("t4_drop_wdata", vwdata, 16'h11F0);
    rd(0); chk("t4_status", dout, 8'hC2);
    pulse_ack(16'h0000);
    rd(0); chk("t4_status2", dout, 8'h02);

    // ack-coincident command switches from write to read without dropping req
    wr(3, 8'h33); chk("t5_waddr", vaddr, 16'h00D0);
    idle(1);
    ack = 1; rdata = 16'h0000; cpu_rd = 1; cpu_addr = 2'd3;
    @(negedge clk);
    ack = 0; cpu_rd = 0;
    chk("t5_req", vreq, 1'b1); chk("t5_we", vwe, 1'b0);
    chk("t5_addr", vaddr, 16'h0102); chk("t5_dout", dout, 8'h56);
    pulse_ack(16'h9ABC);
    chk("t5_model_mawr", m_mawr, 16'h00F0);
    rd(2); chk("t5_lo", dout, 8'hBC);
    wr(0, 8'h05); wr(2, 8'h01); wr(3, 8'h80);
    chk("t5_reg_wr", reg_wr, 1'b1); chk("t5_reg_sel", reg_sel, 5'd5);
    chk("t5_reg_wdata", reg_wdata, 16'h8001);
    idle(1); chk("t5_reg_wr_pulse", reg_wr, 1'b0);

    // reset in the middle of a VRAM cycle
    wr(0, 8'h02); wr(3, 8'h77);
    chk("t6_req", vreq, 1'b1);
    rst_n = 0;
    idle(1);
    chk("t6_req_drop", vreq, 1'b0); chk("t6_busy", busy, 1'b0);
    chk("t6_dout", dout, 8'h00);
    rst_n = 1;
    pulse_ack(16'hFFFF);
    chk("t6_late_ack", vreq, 1'b0);
    rd(0); chk("t6_status", dout, 8'h00);
    wr(0, 8'h02); wr(3, 8'h12);
    chk("t6_addr", vaddr, 16'h0000); chk("t6_wdata", vwdata, 16'h1200);
    pulse_ack(16'h0000);
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
